id_hazard_sb: RTL and testbench

ID_HAZARD_SB -- requirements
Module: id_hazard_sb

---
 rtl/id_hazard_sb_if.sv | 39 +++
 rtl/id_hazard_sb.sv | 95 +++++++++
 tb/tb_id_hazard_sb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_sb_if.sv
// ID-stage hazard scoreboard bus: operand requests, ID write info, slot result data and resolved
// operands / issue control back to the ID stage.
interface id_hazard_sb_if #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
);
  logic                   id_valid_i;
  logic                   id_rs_re_i;
  logic                   id_rt_re_i;
  logic [4:0]             id_rs_addr_i;
  logic [4:0]             id_rt_addr_i;
  logic                   id_wreg_i;
  logic [4:0]             id_wd_i;
  logic                   id_is_load_i;
  logic [31:0]            rs_rf_data_i;
  logic [31:0]            rt_rf_data_i;
  logic [32*DEPTH-1:0]    slot_wdata_i;
  logic                   stall_i;
  logic                   flush_i;
  logic [31:0]            rs_data_o;
  logic [31:0]            rt_data_o;
  logic                   issue_o;
  logic                   stallreq_o;
  logic [CNT_W-1:0]       stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_re_i, id_rt_re_i, id_rs_addr_i, id_rt_addr_i,
           id_wreg_i, id_wd_i, id_is_load_i, rs_rf_data_i, rt_rf_data_i,
           slot_wdata_i, stall_i, flush_i,
    input  rs_data_o, rt_data_o, issue_o, stallreq_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_re_i, id_rt_re_i, id_rs_addr_i, id_rt_addr_i,
           id_wreg_i, id_wd_i, id_is_load_i, rs_rf_data_i, rt_rf_data_i,
           slot_wdata_i, stall_i, flush_i,
    output rs_data_o, rt_data_o, issue_o, stallreq_o, stall_cnt_o
  );
endinterface

// File: rtl/id_hazard_sb.sv
// ID-stage hazard scoreboard: tracks in-flight writers per downstream slot, forwards operands,
// raises load-use stalls and counts hazard-stall cycles.
module id_hazard_sb #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  id_hazard_sb_if.slave sb
);
  localparam logic [2:0] LoadLat = 3'(LOAD_LAT);

  logic [DEPTH-1:0] vld_q;
  logic [4:0]       wd_q  [DEPTH];
  logic [2:0]       lat_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]  op_re;
  logic [4:0]  op_addr [2];
  logic [31:0] op_rf   [2];
  logic [31:0] op_data [2];
  logic [1:0]  op_haz;
  logic        stallreq;
  logic        issue;
  logic        new_vld;

  always_comb begin
    op_re      = {sb.id_rt_re_i, sb.id_rs_re_i};
    op_addr[0] = sb.id_rs_addr_i;
    op_addr[1] = sb.id_rt_addr_i;
    op_rf[0]   = sb.rs_rf_data_i;
    op_rf[1]   = sb.rt_rf_data_i;
  end

  // Scan oldest to youngest so the youngest matching slot is the last assignment and wins.
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      op_data[o] = op_rf[o];
      op_haz[o]  = 1'b0;
      if (!op_re[o] || op_addr[o] == 5'd0) begin
        op_data[o] = '0;
      end else begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (vld_q[k] && wd_q[k] == op_addr[o]) begin
            if (k >= int'(lat_q[k])) begin
              op_data[o] = sb.slot_wdata_i[32*k +: 32];
              op_haz[o]  = 1'b0;
            end else begin
              op_data[o] = op_rf[o];
              op_haz[o]  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    stallreq = rst_n & sb.id_valid_i & (|op_haz) & ~sb.flush_i;
    issue    = rst_n & sb.id_valid_i & ~stallreq & ~sb.stall_i & ~sb.flush_i;
    new_vld  = issue & sb.id_wreg_i & (sb.id_wd_i != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wd_q[k]  <= '0;
        lat_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (!sb.stall_i) begin
        for (int k = 1; k < DEPTH; k++) begin
          vld_q[k] <= vld_q[k-1];
          wd_q[k]  <= wd_q[k-1];
          lat_q[k] <= lat_q[k-1];
        end
        vld_q[0] <= new_vld;
        wd_q[0]  <= new_vld ? sb.id_wd_i : 5'd0;
        lat_q[0] <= (new_vld && sb.id_is_load_i) ? LoadLat : 3'd0;
      end
      if (stallreq && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sb.rs_data_o   = op_data[0];
  assign sb.rt_data_o   = op_data[1];
  assign sb.issue_o     = issue;
  assign sb.stallreq_o  = stallreq;
  assign sb.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_hazard_sb.sv
// Bench for id_hazard_sb: directed table rows, counter saturation/reset sequence and random
// stimulus against a queue-based scoreboard model.
module tb_id_hazard_sb;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_LAT = 1;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CMAX     = (32'd1 << CNT_W) - 1;
  localparam logic [31:0] RS_RF    = 32'h1111_1111;
  localparam logic [31:0] RT_RF    = 32'h2222_2222;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_hazard_sb_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) sb ();

  id_hazard_sb #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  typedef struct {
    bit v; bit rsre; bit [4:0] rsa; bit rtre; bit [4:0] rta;
    bit wreg; bit [4:0] wd; bit ld; bit stl; bit fl;
    bit [31:0] w0; bit [31:0] w1; bit [31:0] w2; bit [31:0] rsrf; bit [31:0] rtrf;
  } stim_t;

  typedef struct {
    stim_t s; bit iss; bit sr; bit [31:0] rs; bit [31:0] rt; bit dd;
  } vec_t;

  typedef struct { bit v; bit [4:0] wd; int lat; } ent_t;

  ent_t        pipe[$];  // pipe[0] is the youngest (EX) entry
  int unsigned m_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tab[24];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void reset_model();
    ent_t e;
    e.v = 1'b0; e.wd = 5'd0; e.lat = 0;
    pipe.delete();
    repeat (DEPTH) pipe.push_back(e);
    m_cnt = 0;
  endfunction

  function automatic void ref_op(input bit re, input bit [4:0] a, input bit [31:0] rf,
                                 input bit [95:0] wdata, output bit [31:0] d, output bit hz);
    int hit = -1;
    d  = rf;
    hz = 1'b0;
    if (!re || a == 5'd0) begin
      d = 32'd0;
      return;
    end
    for (int k = 0; k < pipe.size(); k++)
      if (hit < 0 && pipe[k].v && pipe[k].wd == a) hit = k;
    if (hit >= 0) begin
      if (hit < pipe[hit].lat) hz = 1'b1;
      else d = wdata[32*hit +: 32];
    end
  endfunction

  function automatic vec_t mk(input bit v, input bit rsre, input bit [4:0] rsa, input bit rtre,
                              input bit [4:0] rta, input bit wreg, input bit [4:0] wd,
                              input bit ld, input bit stl, input bit fl, input bit [31:0] w0,
                              input bit [31:0] w1, input bit [31:0] w2, input bit iss,
                              input bit sr, input bit [31:0] rs, input bit [31:0] rt,
                              input bit dd);
    vec_t t;
    t.s = '{v:v, rsre:rsre, rsa:rsa, rtre:rtre, rta:rta, wreg:wreg, wd:wd, ld:ld, stl:stl,
            fl:fl, w0:w0, w1:w1, w2:w2, rsrf:RS_RF, rtrf:RT_RF};
    t.iss = iss; t.sr = sr; t.rs = rs; t.rt = rt; t.dd = dd;
    return t;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.v    = ($urandom_range(0, 9) != 0);
    s.rsre = ($urandom_range(0, 3) != 0);
    s.rsa  = 5'($urandom_range(0, 7));
    s.rtre = ($urandom_range(0, 3) != 0);
    s.rta  = 5'($urandom_range(0, 7));
    s.wreg = ($urandom_range(0, 3) != 0);
    s.wd   = 5'($urandom_range(0, 7));
    s.ld   = ($urandom_range(0, 2) == 0);
    s.stl  = ($urandom_range(0, 6) == 0);
    s.fl   = ($urandom_range(0, 9) == 0);
    s.w0   = $urandom; s.w1 = $urandom; s.w2 = $urandom;
    s.rsrf = $urandom; s.rtrf = $urandom;
    return s;
  endfunction

  task automatic step(input stim_t s, input bit r, input bit use_tab, input vec_t e,
                      input string nm);
    bit [31:0] m_rs, m_rt;
    bit        m_hrs, m_hrt, m_sr, m_iss;
    bit [31:0] x_rs, x_rt;
    bit        x_sr, x_iss, x_dd_rs, x_dd_rt;
    ent_t      ne;
    @(negedge clk);
    rst_n            = r;
    sb.id_valid_i    = s.v;
    sb.id_rs_re_i    = s.rsre;
    sb.id_rs_addr_i  = s.rsa;
    sb.id_rt_re_i    = s.rtre;
    sb.id_rt_addr_i  = s.rta;
    sb.id_wreg_i     = s.wreg;
    sb.id_wd_i       = s.wd;
    sb.id_is_load_i  = s.ld;
    sb.stall_i       = s.stl;
    sb.flush_i       = s.fl;
    sb.slot_wdata_i  = {s.w2, s.w1, s.w0};
    sb.rs_rf_data_i  = s.rsrf;
    sb.rt_rf_data_i  = s.rtrf;
    if (!r) reset_model();
    ref_op(s.rsre, s.rsa, s.rsrf, {s.w2, s.w1, s.w0}, m_rs, m_hrs);
    ref_op(s.rtre, s.rta, s.rtrf, {s.w2, s.w1, s.w0}, m_rt, m_hrt);
    m_sr  = r && s.v && (m_hrs || m_hrt) && !s.fl;
    m_iss = r && s.v && !m_sr && !s.stl && !s.fl;
    #2;
    if (use_tab) begin
      x_iss = e.iss; x_sr = e.sr; x_rs = e.rs; x_rt = e.rt; x_dd_rs = e.dd; x_dd_rt = e.dd;
    end else begin
      x_iss = m_iss; x_sr = m_sr; x_rs = m_rs; x_rt = m_rt; x_dd_rs = m_hrs; x_dd_rt = m_hrt;
    end
    chk({nm, " issue"}, 32'(sb.issue_o), 32'(x_iss));
    chk({nm, " stallreq"}, 32'(sb.stallreq_o), 32'(x_sr));
    if (!x_dd_rs) chk({nm, " rs_data"}, sb.rs_data_o, x_rs);
    if (!x_dd_rt) chk({nm, " rt_data"}, sb.rt_data_o, x_rt);
    chk({nm, " stall_cnt"}, 32'(sb.stall_cnt_o), m_cnt);
    @(posedge clk);
    if (r) begin
      if (m_sr && m_cnt < CMAX) m_cnt++;
      if (!s.stl) begin
        ne.v   = m_iss && s.wreg && (s.wd != 5'd0);
        ne.wd  = ne.v ? s.wd : 5'd0;
        ne.lat = (ne.v && s.ld) ? int'(LOAD_LAT) : 0;
        pipe.push_front(ne);
        void'(pipe.pop_back());
      end
    end
  endtask

  initial begin
    stim_t hold, idle;
    vec_t  none;
    none = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,1);
    idle = none.s;
    reset_model();

    //        v rs a  rt a  wr wd ld st fl  w0         w1            w2          iss sr rs       rt      dd
    tab[0]  = mk(1,0,0, 0,0, 1,3, 0,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[1]  = mk(1,1,3, 1,0, 0,0, 0,0,0, 'h1234,    0,            0,          1,0, 'h1234,  0,      0);
    tab[2]  = mk(1,1,3, 1,9, 0,0, 0,0,0, 0,         'h5678,       0,          1,0, 'h5678,  RT_RF,  0);
    tab[3]  = mk(1,1,3, 0,0, 0,0, 0,0,0, 0,         0,            'h9abc,     1,0, 'h9abc,  0,      0);
    tab[4]  = mk(1,1,3, 0,0, 0,0, 0,0,0, 0,         0,            0,          1,0, RS_RF,   0,      0);
    tab[5]  = mk(1,0,0, 0,0, 1,5, 1,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[6]  = mk(1,0,0, 1,5, 1,6, 0,0,0, 0,         0,            0,          0,1, 0,       0,      1);
    tab[7]  = mk(1,0,0, 1,5, 1,6, 0,0,0, 0,         'hdeadbeef,   0,          1,0, 0,       'hdeadbeef, 0);
    tab[8]  = mk(0,0,0, 0,0, 0,0, 0,0,0, 0,         0,            0,          0,0, 0,       0,      0);
    tab[9]  = mk(1,0,0, 0,0, 1,7, 0,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[10] = mk(1,0,0, 0,0, 1,0, 0,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[11] = mk(1,0,0, 0,0, 1,7, 0,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[12] = mk(1,1,7, 1,0, 0,0, 0,0,0, 'ha,       0,            'hc,        1,0, 'ha,     0,      0);
    tab[13] = mk(1,1,0, 1,7, 0,0, 0,0,0, 0,         'h77,         0,          1,0, 0,       'h77,   0);
    tab[14] = mk(1,0,0, 0,0, 1,8, 1,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[15] = mk(1,1,8, 0,0, 1,9, 0,0,1, 0,         0,            0,          0,0, 0,       0,      1);
    tab[16] = mk(1,1,8, 0,0, 1,9, 0,0,0, 0,         'h88,         0,          1,0, 'h88,    0,      0);
    tab[17] = mk(1,1,9, 1,8, 0,0, 0,0,0, 'h99,      0,            'h8888,     1,0, 'h99,    'h8888, 0);
    tab[18] = mk(1,0,0, 0,0, 1,10,1,0,0, 0,         0,            0,          1,0, 0,       0,      0);
    tab[19] = mk(1,1,10,0,0, 0,0, 0,1,0, 0,         0,            0,          0,1, 0,       0,      1);
    tab[20] = mk(1,1,10,0,0, 0,0, 0,1,0, 0,         0,            0,          0,1, 0,       0,      1);
    tab[21] = mk(1,1,10,0,0, 0,0, 0,1,0, 0,         0,            0,          0,1, 0,       0,      1);
    tab[22] = mk(1,1,10,0,0, 0,0, 0,0,0, 0,         0,            0,          0,1, 0,       0,      1);
    tab[23] = mk(1,1,10,0,0, 0,0, 0,0,0, 0,         'h1010,       0,          1,0, 'h1010,  0,      0);

    // Reset state: valid ID reading $3 while held in reset.
    hold = tab[4].s;
    step(hold, 1'b0, 1'b1, mk(1,1,3,0,0,0,0,0,0,0,0,0,0, 0,0,RS_RF,0,0), "reset");
    step(hold, 1'b0, 1'b0, none, "reset2");

    for (int i = 0; i < 24; i++) step(tab[i].s, 1'b1, 1'b1, tab[i], $sformatf("row%0d", i));
    #2 chk("cnt after table", 32'(sb.stall_cnt_o), 32'd5);

    // Counter saturation: load stays frozen in EX under stall_i while ID keeps reading it.
    step(mk(1,0,0,0,0,1,20,1,0,0,0,0,0,0,0,0,0,0).s, 1'b1, 1'b0, none, "sat_load");
    hold = mk(1,1,20,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0).s;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step(hold, 1'b1, 1'b0, none, "sat");
    #2 chk("cnt saturated", 32'(sb.stall_cnt_o), 32'hffff);
    step(hold, 1'b0, 1'b0, none, "sat_rst");
    #2 chk("cnt after reset", 32'(sb.stall_cnt_o), 32'd0);
    step(hold, 1'b1, 1'b0, none, "post_rst");
    step(idle, 1'b1, 1'b0, none, "idle");

    for (int i = 0; i < 3000; i++)
      step(rnd_stim(), ($urandom_range(0, 99) != 0), 1'b0, none, $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
